// File: rtl/pwm_carrier_nch.sv
// N-channel PWM generator: one shared prescaled carrier (up/down/up-down/hold)
// drives N_CH compare channels, each with a dead-time protected complementary A/B pair.
module pwm_carrier_nch #(
    parameter int CNT_W = 16,
    parameter int N_CH  = 4,
    parameter int DIV_W = 8,
    parameter int DT_W  = 10,
    parameter int INT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        period,
    input  logic [CNT_W-1:0]        init_carr,
    input  logic [N_CH*CNT_W-1:0]   compare,
    input  logic [N_CH*DT_W-1:0]    dtime,
    input  logic [DIV_W-1:0]        pwmclk_divider,
    input  logic [1:0]              count_mode,
    input  logic [1:0]              mask_mode,
    input  logic                    pwm_onoff,
    input  logic                    int_onoff,
    input  logic [INT_W-1:0]        event_count,
    input  logic [N_CH-1:0]         pol_A,
    input  logic [N_CH-1:0]         pol_B,
    output logic [CNT_W-1:0]        carrier,
    output logic [N_CH-1:0]         pwmout_A,
    output logic [N_CH-1:0]         pwmout_B,
    output logic                    shadow_load,
    output logic                    interrupt
);

    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_UPDOWN = 2'd2;
    localparam logic [1:0] MASK_MIN    = 2'd0;
    localparam logic [1:0] MASK_MAX    = 2'd1;
    localparam logic [1:0] MASK_MINMAX = 2'd2;

    logic [CNT_W-1:0]      carrier_q, carrier_d;
    logic                  dir_down_q, dir_down_d;
    logic [DIV_W-1:0]      presc_q, presc_d;
    logic [CNT_W-1:0]      period_sh_q, period_sh_d;
    logic [CNT_W-1:0]      init_sh_q, init_sh_d;
    logic [N_CH*CNT_W-1:0] cmp_sh_q, cmp_sh_d;
    logic [INT_W-1:0]      ev_cnt_q, ev_cnt_d;
    logic                  shadow_load_q, shadow_load_d;
    logic                  interrupt_q, interrupt_d;

    logic                  tick, ev_min, ev_max, sel_ev, load_ev;
    logic [CNT_W-1:0]      carrier_next;
    logic                  dir_down_next;
    logic [N_CH-1:0]       raw;

    assign tick   = (presc_q == pwmclk_divider);
    assign ev_min = tick && (carrier_q == '0);
    assign ev_max = tick && (carrier_q == period_sh_q);

    always_comb begin
        sel_ev = 1'b0;
        case (mask_mode)
            MASK_MIN:    sel_ev = ev_min;
            MASK_MAX:    sel_ev = ev_max;
            MASK_MINMAX: sel_ev = ev_min || ev_max;
            default:     sel_ev = ev_min || ev_max;
        endcase
        load_ev = (mask_mode == 2'd3) || sel_ev;
    end

    // Carrier value the next tick would produce; out-of-range values snap to 0.
    always_comb begin
        carrier_next  = carrier_q;
        dir_down_next = dir_down_q;
        if (count_mode != 2'd3) begin
            if (period_sh_q == '0 || carrier_q > period_sh_q) begin
                carrier_next  = '0;
                dir_down_next = 1'b0;
            end else begin
                case (count_mode)
                    MODE_UP:
                        carrier_next = (carrier_q == period_sh_q) ? '0 : carrier_q + 1'b1;
                    MODE_DOWN:
                        carrier_next = (carrier_q == '0) ? period_sh_q : carrier_q - 1'b1;
                    MODE_UPDOWN: begin
                        if (carrier_q == period_sh_q)
                            dir_down_next = 1'b1;
                        else if (carrier_q == '0)
                            dir_down_next = 1'b0;
                        carrier_next = dir_down_next ? carrier_q - 1'b1 : carrier_q + 1'b1;
                    end
                    default: carrier_next = carrier_q;
                endcase
            end
        end
    end

    always_comb begin
        carrier_d     = carrier_q;
        dir_down_d    = dir_down_q;
        presc_d       = presc_q;
        period_sh_d   = period_sh_q;
        init_sh_d     = init_sh_q;
        cmp_sh_d      = cmp_sh_q;
        ev_cnt_d      = ev_cnt_q;
        shadow_load_d = 1'b0;
        interrupt_d   = 1'b0;
        if (!pwm_onoff) begin
            period_sh_d = period;
            init_sh_d   = init_carr;
            cmp_sh_d    = compare;
            carrier_d   = init_carr;
            dir_down_d  = 1'b0;
            presc_d     = '0;
            ev_cnt_d    = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                carrier_d  = carrier_next;
                dir_down_d = dir_down_next;
            end
            if (load_ev) begin
                period_sh_d   = period;
                init_sh_d     = init_carr;
                cmp_sh_d      = compare;
                shadow_load_d = 1'b1;
            end
            if (!int_onoff) begin
                ev_cnt_d = '0;
            end else if (sel_ev) begin
                if (ev_cnt_q == event_count) begin
                    ev_cnt_d    = '0;
                    interrupt_d = 1'b1;
                end else begin
                    ev_cnt_d = ev_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carrier_q     <= '0;
            dir_down_q    <= 1'b0;
            presc_q       <= '0;
            period_sh_q   <= '0;
            init_sh_q     <= '0;
            cmp_sh_q      <= '0;
            ev_cnt_q      <= '0;
            shadow_load_q <= 1'b0;
            interrupt_q   <= 1'b0;
        end else begin
            carrier_q     <= carrier_d;
            dir_down_q    <= dir_down_d;
            presc_q       <= presc_d;
            period_sh_q   <= period_sh_d;
            init_sh_q     <= init_sh_d;
            cmp_sh_q      <= cmp_sh_d;
            ev_cnt_q      <= ev_cnt_d;
            shadow_load_q <= shadow_load_d;
            interrupt_q   <= interrupt_d;
        end
    end

    assign carrier     = carrier_q;
    assign shadow_load = shadow_load_q;
    assign interrupt   = interrupt_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DT_W-1:0] dt_cnt_q, dt_cnt_d, hold;
            logic            raw_prev_q, raw_prev_d;
            logic            pwm_a_q, pwm_a_d, pwm_b_q, pwm_b_d;

            assign raw[gi] = (carrier_q < cmp_sh_q[gi*CNT_W +: CNT_W]);

            // hold is the remaining dead time after this clk; both sides stay off until it hits 0.
            always_comb begin
                if (raw[gi] != raw_prev_q)
                    hold = dtime[gi*DT_W +: DT_W];
                else if (dt_cnt_q != '0)
                    hold = dt_cnt_q - 1'b1;
                else
                    hold = '0;

                dt_cnt_d   = '0;
                raw_prev_d = raw[gi];
                pwm_a_d    = pol_A[gi];
                pwm_b_d    = pol_B[gi];
                if (pwm_onoff) begin
                    dt_cnt_d = hold;
                    pwm_a_d  = ((hold == '0) && raw[gi]) ^ pol_A[gi];
                    pwm_b_d  = ((hold == '0) && !raw[gi]) ^ pol_B[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dt_cnt_q   <= '0;
                    raw_prev_q <= 1'b0;
                    pwm_a_q    <= 1'b0;
                    pwm_b_q    <= 1'b0;
                end else begin
                    dt_cnt_q   <= dt_cnt_d;
                    raw_prev_q <= raw_prev_d;
                    pwm_a_q    <= pwm_a_d;
                    pwm_b_q    <= pwm_b_d;
                end
            end

            assign pwmout_A[gi] = pwm_a_q;
            assign pwmout_B[gi] = pwm_b_q;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_carrier_nch.sv
// Directed bench for pwm_carrier_nch: a table of run-length vectors plus
// hand-written sequences for shadowing, interrupts, dead time, stop and reset.
module tb_pwm_carrier_nch;

    localparam int CNT_W = 16;
    localparam int N_CH  = 4;
    localparam int DIV_W = 8;
    localparam int DT_W  = 10;
    localparam int INT_W = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [CNT_W-1:0]      period, init_carr;
    logic [N_CH*CNT_W-1:0] compare;
    logic [N_CH*DT_W-1:0]  dtime;
    logic [DIV_W-1:0]      pwmclk_divider;
    logic [1:0]            count_mode, mask_mode;
    logic                  pwm_onoff, int_onoff;
    logic [INT_W-1:0]      event_count;
    logic [N_CH-1:0]       pol_A, pol_B;
    logic [CNT_W-1:0]      carrier;
    logic [N_CH-1:0]       pwmout_A, pwmout_B;
    logic                  shadow_load, interrupt;

    pwm_carrier_nch #(.CNT_W(CNT_W), .N_CH(N_CH), .DIV_W(DIV_W), .DT_W(DT_W), .INT_W(INT_W)) dut (
        .clk(clk), .reset(reset), .period(period), .init_carr(init_carr),
        .compare(compare), .dtime(dtime), .pwmclk_divider(pwmclk_divider),
        .count_mode(count_mode), .mask_mode(mask_mode), .pwm_onoff(pwm_onoff),
        .int_onoff(int_onoff), .event_count(event_count), .pol_A(pol_A), .pol_B(pol_B),
        .carrier(carrier), .pwmout_A(pwmout_A), .pwmout_B(pwmout_B),
        .shadow_load(shadow_load), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] per;
        logic [15:0] init;
        logic [15:0] cmp0;
        logic [7:0]  div;
        logic [9:0]  dt0;
        logic [3:0]  pola;
        logic [3:0]  polb;
        int          k;
        logic [15:0] exp_carr;
        logic [3:0]  exp_a;
        logic [3:0]  exp_b;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    logic ovl_en = 1'b0;
    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ovl_en)
                check("ab_overlap", 32'((pwmout_A ^ pol_A) & (pwmout_B ^ pol_B)), 32'd0);
        end
    endtask

    // Stop the block, apply a configuration, and let the shadows settle.
    task automatic configure(input logic [1:0] mode, input logic [1:0] mask, input logic [15:0] per,
                             input logic [15:0] init, input logic [15:0] cmp0, input logic [7:0] div,
                             input logic [9:0] dt0, input logic [3:0] pola, input logic [3:0] polb);
        pwm_onoff      = 1'b0;
        count_mode     = mode;
        mask_mode      = mask;
        period         = per;
        init_carr      = init;
        compare        = '0;
        compare[15:0]  = cmp0;
        dtime          = '0;
        dtime[9:0]     = dt0;
        pwmclk_divider = div;
        pol_A          = pola;
        pol_B          = polb;
        int_onoff      = 1'b0;
        event_count    = '0;
        step(2);
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input logic [15:0] per, input logic [15:0] init,
                                input logic [15:0] cmp0, input logic [7:0] div, input logic [9:0] dt0,
                                input logic [3:0] pola, input logic [3:0] polb, input int k,
                                input logic [15:0] ec, input logic [3:0] ea, input logic [3:0] eb);
        vec_t v;
        v.mode = mode; v.per = per; v.init = init; v.cmp0 = cmp0; v.div = div; v.dt0 = dt0;
        v.pola = pola; v.polb = polb; v.k = k; v.exp_carr = ec; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    initial begin
        int   n_gaps, t_afall, t_bfall, pulses;
        logic pa, pb;

        //                 mode   P      init   cmp    div   dt      polA     polB     k   carr   A        B
        vecs[0]  = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 1,  16'd1, 4'b0001, 4'b1110);
        vecs[1]  = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 6,  16'd6, 4'b0000, 4'b1111);
        vecs[2]  = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 10, 16'd0, 4'b0000, 4'b1111);
        vecs[3]  = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 11, 16'd1, 4'b0001, 4'b1110);
        vecs[4]  = mk(2'd1, 16'd9, 16'd9,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 3,  16'd6, 4'b0000, 4'b1111);
        vecs[5]  = mk(2'd1, 16'd9, 16'd9,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 6,  16'd3, 4'b0001, 4'b1110);
        vecs[6]  = mk(2'd1, 16'd9, 16'd9,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 10, 16'd9, 4'b0001, 4'b1110);
        vecs[7]  = mk(2'd2, 16'd4, 16'd0,  16'd2,  8'd0, 10'd0,  4'b0000, 4'b0000, 6,  16'd2, 4'b0000, 4'b1111);
        vecs[8]  = mk(2'd2, 16'd4, 16'd0,  16'd2,  8'd0, 10'd0,  4'b0000, 4'b0000, 9,  16'd1, 4'b0001, 4'b1110);
        vecs[9]  = mk(2'd3, 16'd9, 16'd3,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 5,  16'd3, 4'b0001, 4'b1110);
        vecs[10] = mk(2'd0, 16'd9, 16'd12, 16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 2,  16'd1, 4'b0001, 4'b1110);
        vecs[11] = mk(2'd0, 16'd0, 16'd0,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b0000, 4,  16'd0, 4'b0001, 4'b1110);
        vecs[12] = mk(2'd0, 16'd9, 16'd0,  16'd0,  8'd0, 10'd0,  4'b1111, 4'b0000, 3,  16'd3, 4'b1111, 4'b1111);
        vecs[13] = mk(2'd0, 16'd9, 16'd0,  16'd10, 8'd0, 10'd0,  4'b0000, 4'b0000, 10, 16'd0, 4'b0001, 4'b1110);
        vecs[14] = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd2, 10'd0,  4'b0000, 4'b0000, 7,  16'd2, 4'b0001, 4'b1110);
        vecs[15] = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd3,  4'b0000, 4'b0000, 8,  16'd8, 4'b0000, 4'b1110);
        vecs[16] = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd3,  4'b0000, 4'b0000, 9,  16'd9, 4'b0000, 4'b1111);
        vecs[17] = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd3,  4'b0000, 4'b0000, 13, 16'd3, 4'b0000, 4'b1110);
        vecs[18] = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd3,  4'b0000, 4'b0000, 14, 16'd4, 4'b0001, 4'b1110);
        vecs[19] = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd20, 4'b0000, 4'b0000, 30, 16'd0, 4'b0000, 4'b1110);
        vecs[20] = mk(2'd0, 16'd9, 16'd0,  16'd5,  8'd0, 10'd0,  4'b0000, 4'b1111, 1,  16'd1, 4'b0001, 4'b0001);

        // Reset state, with non-zero polarities to show reset wins over them.
        reset = 1'b1;
        configure(2'd0, 2'd0, 16'd9, 16'd3, 16'd5, 8'd0, 10'd0, 4'b1010, 4'b0110);
        check("rst_carrier", 32'(carrier), 32'd0);
        check("rst_pwmout_A", 32'(pwmout_A), 32'd0);
        check("rst_pwmout_B", 32'(pwmout_B), 32'd0);
        check("rst_shadow_load", 32'(shadow_load), 32'd0);
        check("rst_interrupt", 32'(interrupt), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            configure(vecs[i].mode, 2'd0, vecs[i].per, vecs[i].init, vecs[i].cmp0, vecs[i].div,
                      vecs[i].dt0, vecs[i].pola, vecs[i].polb);
            pwm_onoff = 1'b1;
            step(vecs[i].k);
            check($sformatf("vec%0d_carrier", i), 32'(carrier), 32'(vecs[i].exp_carr));
            check($sformatf("vec%0d_pwmout_A", i), 32'(pwmout_A), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d_pwmout_B", i), 32'(pwmout_B), 32'(vecs[i].exp_b));
        end

        // MAX-event shadowing of compare: new duty only after the carrier==P tick.
        configure(2'd0, 2'd1, 16'd9, 16'd0, 16'd5, 8'd0, 10'd0, 4'b0000, 4'b0000);
        pwm_onoff = 1'b1;
        step(3);
        compare[15:0] = 16'd2;
        step(2);
        check("shcmp_old_duty_A", 32'(pwmout_A), 32'b0001);
        step(4);
        check("shcmp_carrier_at_max", 32'(carrier), 32'd9);
        check("shcmp_no_load_yet", 32'(shadow_load), 32'd0);
        step(1);
        check("shcmp_load_pulse", 32'(shadow_load), 32'd1);
        step(1);
        check("shcmp_load_pulse_end", 32'(shadow_load), 32'd0);
        step(1);
        check("shcmp_new_duty_hi", 32'(pwmout_A), 32'b0001);
        step(1);
        check("shcmp_new_duty_lo", 32'(pwmout_A), 32'b0000);

        // MAX-event shadowing of period: carrier finishes the old period first.
        configure(2'd0, 2'd1, 16'd9, 16'd0, 16'd5, 8'd0, 10'd0, 4'b0000, 4'b0000);
        pwm_onoff = 1'b1;
        step(3);
        period = 16'd6;
        step(6);
        check("shper_old_period", 32'(carrier), 32'd9);
        step(7);
        check("shper_new_top", 32'(carrier), 32'd6);
        step(1);
        check("shper_new_wrap", 32'(carrier), 32'd0);

        // Interrupt on every 3rd MIN/MAX event of an up-down carrier with P=4.
        configure(2'd2, 2'd2, 16'd4, 16'd0, 16'd2, 8'd0, 10'd0, 4'b0000, 4'b0000);
        event_count = 4'd2;
        int_onoff   = 1'b1;
        pwm_onoff   = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step(1);
            check($sformatf("int_clk%0d", c), 32'(interrupt), 32'((c == 9) || (c == 21)));
        end
        int_onoff = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (interrupt) pulses++;
        end
        check("int_disabled_pulses", 32'(pulses), 32'd0);

        // Dead-time gap on an up-down carrier with a prescaler; A and B never overlap.
        configure(2'd2, 2'd0, 16'd20, 16'd5, 16'd10, 8'd2, 10'd4, 4'b0000, 4'b0000);
        pwm_onoff = 1'b1;
        ovl_en    = 1'b1;
        n_gaps = 0; t_afall = -1; t_bfall = -1;
        pa = pwmout_A[0]; pb = pwmout_B[0];
        for (int c = 0; c < 400; c++) begin
            step(1);
            if (pa && !pwmout_A[0]) t_afall = c;
            if (pb && !pwmout_B[0]) t_bfall = c;
            if (!pb && pwmout_B[0] && t_afall >= 0) begin
                check("dt_gap_A_to_B", 32'(c - t_afall), 32'd4);
                n_gaps++;
            end
            if (!pa && pwmout_A[0] && t_bfall >= 0) begin
                check("dt_gap_B_to_A", 32'(c - t_bfall), 32'd4);
                n_gaps++;
            end
            pa = pwmout_A[0]; pb = pwmout_B[0];
        end
        ovl_en = 1'b0;
        check("dt_gaps_seen", 32'(n_gaps >= 2), 32'd1);

        // Mid-run stop and restart from init_carr.
        configure(2'd0, 2'd0, 16'd9, 16'd3, 16'd5, 8'd0, 10'd0, 4'b1010, 4'b0110);
        pwm_onoff = 1'b1;
        step(7);
        check("stop_pre_carrier", 32'(carrier), 32'd0);
        pwm_onoff = 1'b0;
        step(1);
        check("stop_carrier_init", 32'(carrier), 32'd3);
        check("stop_pwmout_A_pol", 32'(pwmout_A), 32'b1010);
        check("stop_pwmout_B_pol", 32'(pwmout_B), 32'b0110);
        pwm_onoff = 1'b1;
        step(1);
        check("restart_carrier", 32'(carrier), 32'd4);
        check("restart_pwmout_A", 32'(pwmout_A), 32'b1011);
        check("restart_pwmout_B", 32'(pwmout_B), 32'b1000);

        // Mid-run reset forces all outputs low on the next clk.
        step(3);
        reset = 1'b1;
        step(1);
        check("midrst_carrier", 32'(carrier), 32'd0);
        check("midrst_pwmout_A", 32'(pwmout_A), 32'd0);
        check("midrst_pwmout_B", 32'(pwmout_B), 32'd0);
        check("midrst_shadow_load", 32'(shadow_load), 32'd0);
        reset = 1'b0;
        pwm_onoff = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
